// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
// Shared definitions for the instruction fetch stage: FSM state encoding,
// the bubble instruction, the PC increment, the default reset PC and a
// helper that forces a fetch address onto a word boundary.
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] PC_INCR          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Clear the two low address bits so every PC is word aligned.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// -----------------------------------------------------------------------------
// fetch_skid_buffer
// One-entry holding register for an instruction that returned from memory
// while decode was stalled.
// Ports:
//   clk, reset_n      clock / asynchronous active-low reset
//   load_i            capture instr_i/pc4_i and mark the entry valid
//   clear_i           drop the entry (has priority over load_i)
//   instr_i, pc4_i    instruction and its PC+4 to capture
//   instr_o, pc4_o    buffered instruction and PC+4
//   valid_o           entry holds a real instruction
// -----------------------------------------------------------------------------
module fetch_skid_buffer
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc4_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc4_o,
    output logic        valid_o
);

    logic [31:0] instr_q;
    logic [31:0] pc4_q;
    logic        valid_q;

    // Buffer entry: clear wins over load, otherwise hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'h0000_0000;
            valid_q <= 1'b0;
        end else if (clear_i) begin
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'h0000_0000;
            valid_q <= 1'b0;
        end else if (load_i) begin
            instr_q <= instr_i;
            pc4_q   <= pc4_i;
            valid_q <= 1'b1;
        end else begin
            instr_q <= instr_q;
            pc4_q   <= pc4_q;
            valid_q <= valid_q;
        end
    end

    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch stage with IF/ID pipeline register. Requests one word per
// cycle, buffers a returning instruction when decode stalls, and handles
// redirects (taken branch / jump) including one already in flight.
// Ports:
//   clk, reset_n                 clock / asynchronous active-low reset
//   imem_req, imem_addr          fetch request and word-aligned address
//   imem_ready, imem_rdata       response strobe and returned instruction
//   stall                        freeze PC and IF/ID
//   redirect, redirect_target    change of flow from decode
//   if_id_instr/pc4/valid        registered IF/ID outputs (valid=0 is bubble)
// -----------------------------------------------------------------------------
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  old_addr_q;   // address still outstanding while discarding
    logic [31:0]  instr_q;
    logic [31:0]  pc4_q;
    logic         valid_q;

    logic [31:0]  pc_plus4_s;
    logic [31:0]  target_s;
    logic         skid_load_s;
    logic         skid_clear_s;
    logic [31:0]  skid_instr_s;
    logic [31:0]  skid_pc4_s;
    logic         skid_valid_s;

    assign pc_plus4_s = pc_q + PC_INCR;   // wraps modulo 2^32
    assign target_s   = align_pc(redirect_target);

    // Skid buffer control: capture on a stalled response, empty on leaving HOLD.
    always_comb begin
        skid_load_s  = 1'b0;
        skid_clear_s = 1'b0;
        case (state_q)
            FETCH:   skid_load_s  = imem_ready & stall;
            HOLD:    skid_clear_s = ~stall;
            DISCARD: skid_clear_s = 1'b0;
            default: skid_clear_s = 1'b1;
        endcase
    end

    fetch_skid_buffer u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (skid_load_s),
        .clear_i (skid_clear_s),
        .instr_i (imem_rdata),
        .pc4_i   (pc_plus4_s),
        .instr_o (skid_instr_s),
        .pc4_o   (skid_pc4_s),
        .valid_o (skid_valid_s)
    );

    // Fetch FSM with PC and IF/ID register updates; redirect only counts when not stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= FETCH;
            pc_q       <= align_pc(RESET_PC);
            old_addr_q <= align_pc(RESET_PC);
            instr_q    <= NOP_INSTR;
            pc4_q      <= 32'h0000_0000;
            valid_q    <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (stall) begin
                        if (imem_ready) begin
                            pc_q    <= pc_plus4_s;
                            state_q <= HOLD;
                        end else begin
                            pc_q    <= pc_q;
                        end
                    end else if (redirect) begin
                        instr_q <= NOP_INSTR;
                        pc4_q   <= 32'h0000_0000;
                        valid_q <= 1'b0;
                        pc_q    <= target_s;
                        if (!imem_ready) begin
                            // Request stays on the bus at the old address until answered.
                            old_addr_q <= pc_q;
                            state_q    <= DISCARD;
                        end else begin
                            state_q    <= FETCH;
                        end
                    end else if (imem_ready) begin
                        instr_q <= imem_rdata;
                        pc4_q   <= pc_plus4_s;
                        valid_q <= 1'b1;
                        pc_q    <= pc_plus4_s;
                    end else begin
                        instr_q <= NOP_INSTR;
                        pc4_q   <= 32'h0000_0000;
                        valid_q <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        if (redirect) begin
                            instr_q <= NOP_INSTR;
                            pc4_q   <= 32'h0000_0000;
                            valid_q <= 1'b0;
                            pc_q    <= target_s;
                        end else begin
                            instr_q <= skid_instr_s;
                            pc4_q   <= skid_pc4_s;
                            valid_q <= skid_valid_s;
                        end
                        state_q <= FETCH;
                    end else begin
                        state_q <= HOLD;
                    end
                end
                DISCARD: begin
                    instr_q <= NOP_INSTR;
                    pc4_q   <= 32'h0000_0000;
                    valid_q <= 1'b0;
                    if (redirect && !stall) begin
                        pc_q <= target_s;
                    end else begin
                        pc_q <= pc_q;
                    end
                    if (imem_ready) begin
                        state_q <= FETCH;
                    end else begin
                        state_q <= DISCARD;
                    end
                end
                default: begin
                    state_q <= FETCH;
                    instr_q <= NOP_INSTR;
                    pc4_q   <= 32'h0000_0000;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Request is dropped while reset is asserted and while holding a buffered word.
    assign imem_req    = reset_n & (state_q != HOLD);
    assign imem_addr   = (state_q == DISCARD) ? old_addr_q : pc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Directed scenarios with literal expectations followed by randomized traffic,
// all compared every cycle against a transaction-level model of the stage.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .if_id_instr     (if_id_instr),
        .if_id_pc4       (if_id_pc4),
        .if_id_valid     (if_id_valid)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state: next PC, an outstanding request to be thrown away,
    // at most one instruction parked while decode is stalled, and IF/ID contents.
    logic [31:0] m_pc;
    bit          m_drop_pending;
    logic [31:0] m_drop_addr;
    logic [63:0] m_parked[$];
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    bit          m_valid;

    // Instruction memory contents as a pure function of address.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc           = 32'h0000_0000;
        m_drop_pending = 1'b0;
        m_drop_addr    = 32'h0000_0000;
        m_parked.delete();
        m_instr        = 32'h0;
        m_pc4          = 32'h0;
        m_valid        = 1'b0;
    endtask

    task automatic model_bubble();
        m_instr = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
    endtask

    // One clock of the stage, described in terms of what happens to instructions.
    task automatic model_step(input bit r, input bit s, input bit rd, input logic [31:0] t);
        logic [31:0] tgt;
        logic [63:0] entry;
        tgt = t & 32'hFFFF_FFFC;
        if (m_parked.size() != 0) begin
            if (!s) begin
                entry = m_parked.pop_front();
                if (rd) begin
                    model_bubble();
                    m_pc = tgt;
                end else begin
                    m_instr = entry[63:32];
                    m_pc4   = entry[31:0];
                    m_valid = 1'b1;
                end
            end
        end else if (m_drop_pending) begin
            model_bubble();
            if (!s && rd) m_pc = tgt;
            if (r) m_drop_pending = 1'b0;
        end else if (s) begin
            if (r) begin
                m_parked.push_back({mem(m_pc), m_pc + 32'd4});
                m_pc = m_pc + 32'd4;
            end
        end else if (rd) begin
            model_bubble();
            if (!r) begin
                m_drop_pending = 1'b1;
                m_drop_addr    = m_pc;
            end
            m_pc = tgt;
        end else if (r) begin
            m_instr = mem(m_pc);
            m_pc4   = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
        end else begin
            model_bubble();
        end
    endtask

    task automatic compare_model();
        logic [31:0] exp_addr;
        exp_addr = m_drop_pending ? m_drop_addr : m_pc;
        check("imem_req",    {31'b0, imem_req},    {31'b0, (m_parked.size() == 0)});
        if (m_parked.size() == 0) check("imem_addr", imem_addr, exp_addr);
        check("if_id_instr", if_id_instr,           m_instr);
        check("if_id_pc4",   if_id_pc4,             m_pc4);
        check("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
    endtask

    // Drive one cycle of inputs (memory answers at the presented address),
    // advance the model, then compare at the following falling edge.
    task automatic drive_cycle(input bit r, input bit s, input bit rd, input logic [31:0] t);
        imem_ready      = r;
        stall           = s;
        redirect        = rd;
        redirect_target = t;
        imem_rdata      = r ? mem(imem_addr) : $urandom();
        model_step(r, s, rd, t);
        @(negedge clk);
        compare_model();
    endtask

    task automatic pulse_reset();
        #2 reset_n = 1'b0;
        #1;
        check("rst_req",   {31'b0, imem_req},    32'h0);
        check("rst_addr",  imem_addr,            32'h0000_0000);
        check("rst_instr", if_id_instr,          32'h0);
        check("rst_pc4",   if_id_pc4,            32'h0);
        check("rst_valid", {31'b0, if_id_valid}, 32'h0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("post_rst_req", {31'b0, imem_req}, 32'h1);
        compare_model();
    endtask

    initial begin
        reset_n         = 1'b0;
        imem_ready      = 1'b0;
        imem_rdata      = 32'h0;
        stall           = 1'b0;
        redirect        = 1'b0;
        redirect_target = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);
        check("init_req",   {31'b0, imem_req},    32'h0);
        check("init_valid", {31'b0, if_id_valid}, 32'h0);
        check("init_pc4",   if_id_pc4,            32'h0);
        reset_n = 1'b1;
        #1;
        check("first_req",  {31'b0, imem_req}, 32'h1);
        check("first_addr", imem_addr,         32'h0000_0000);
        compare_model();

        // Streaming with ready always high.
        drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("s_addr1", imem_addr, 32'h4);
        check("s_pc4_1", if_id_pc4, 32'h4);
        drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("s_addr2", imem_addr, 32'h8);
        check("s_pc4_2", if_id_pc4, 32'h8);

        // Response at 0x8 during a 3-cycle stall is parked, then released once.
        drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check("st_pc4_a", if_id_pc4, 32'h8);
        drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        drive_cycle(1'b0, 1'b1, 1'b1, 32'h500);
        check("st_pc4_c", if_id_pc4, 32'h8);
        drive_cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check("rel_pc4",   if_id_pc4,   32'hC);
        check("rel_instr", if_id_instr, mem(32'h8));
        check("rel_addr",  imem_addr,   32'hC);
        drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("rel_next_pc4", if_id_pc4, 32'h10);

        // Redirect with data returning: bubble, next address is the target.
        drive_cycle(1'b1, 1'b0, 1'b1, 32'h40);
        check("rd_valid", {31'b0, if_id_valid}, 32'h0);
        check("rd_addr",  imem_addr,            32'h40);

        // Redirect while the request at 0x10 is waiting.
        drive_cycle(1'b1, 1'b0, 1'b1, 32'h10);
        drive_cycle(1'b0, 1'b0, 1'b1, 32'h80);
        check("dw_addr0", imem_addr, 32'h10);
        drive_cycle(1'b0, 1'b0, 1'b0, 32'h0);
        drive_cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check("dw_addr2", imem_addr, 32'h10);
        drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("dw_addr3",  imem_addr,            32'h80);
        check("dw_valid3", {31'b0, if_id_valid}, 32'h0);
        drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("dw_pc4", if_id_pc4, 32'h84);

        // Redirect under stall is ignored; then PC wraps at the top of memory.
        drive_cycle(1'b0, 1'b1, 1'b1, 32'h200);
        check("rs_addr", imem_addr, 32'h84);
        check("rs_pc4",  if_id_pc4, 32'h84);
        drive_cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
        check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("wrap_addr1",  imem_addr,   32'h0);
        check("wrap_pc4",    if_id_pc4,   32'h0);
        check("wrap_instr",  if_id_instr, mem(32'hFFFF_FFFC));

        // Reset while a discarded request is outstanding.
        drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
        drive_cycle(1'b0, 1'b0, 1'b1, 32'h300);
        check("pre_rst_addr", imem_addr, 32'h4);
        pulse_reset();
        drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("after_rst_pc4",   if_id_pc4,   32'h4);
        check("after_rst_instr", if_id_instr, mem(32'h0));

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit          r;
            bit          s;
            bit          rd;
            logic [31:0] t;
            r  = ($urandom_range(0, 9) < 6);
            s  = ($urandom_range(0, 9) < 3);
            rd = ($urandom_range(0, 9) < 1);
            t  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + $urandom_range(0, 15)) : $urandom();
            drive_cycle(r, s, rd, t);
            if ($urandom_range(0, 299) == 0) pulse_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
